// File: rtl/wupr_refresh_scheduler.sv
// Refresh sequencer in front of the WUPR written-row tracker.
// A tREFI timer accrues owed refresh slots. For each owed slot the FSM
// asks WUPR whether the current row needs a refresh (to_refresh/dref).
// If it does, a request goes to the command scheduler and tRFC is waited
// out; if not, the row is skipped. Either way the row pointer then advances.
module wupr_refresh_scheduler #(
    parameter int ROW_WIDTH   = 16,
    parameter int TREFI       = 7800,
    parameter int TRFC        = 350,
    parameter int DREF_LAT    = 1,
    parameter int MAX_PENDING = 8,
    parameter int URGENT_TH   = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 refresh_en_i,
    input  logic                 wr_busy_i,
    output logic                 to_refresh_o,
    output logic [ROW_WIDTH-1:0] ref_row_o,
    output logic                 clk_enable_o,
    input  logic                 dref_i,
    output logic                 ref_req_o,
    input  logic                 ref_ack_i,
    output logic                 ref_urgent_o,
    output logic [3:0]           pending_o,
    output logic [15:0]          skip_cnt_o
);

    localparam int TMR_W   = $clog2(TREFI);
    localparam int CNT_MAX = (TRFC > DREF_LAT) ? TRFC : DREF_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TREFI - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(DREF_LAT - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD   = CNT_W'(TRFC - 1);
    localparam logic [3:0]       PEND_MAX   = 4'(MAX_PENDING);
    localparam logic [3:0]       PEND_URG   = 4'(URGENT_TH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [3:0]           pend_q, pend_d;
    logic [15:0]          skip_q, skip_d;
    logic                 tick_s;
    logic                 complete_s;

    // tREFI timer: counts down while enabled, ticks and reloads at zero.
    always_comb begin
        tick_s  = 1'b0;
        timer_d = timer_q;
        if (refresh_en_i) begin
            if (timer_q == '0) begin
                tick_s  = 1'b1;
                timer_d = TMR_RELOAD;
            end else begin
                timer_d = timer_q - TMR_W'(1);
            end
        end else begin
            timer_d = timer_q;
        end
    end

    // Slot FSM: lookup, dref decision, request/ack handshake, recovery.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        skip_d     = skip_q;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((pend_q != 4'd0) && !wr_busy_i) begin
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                // A write that appears late still owns Ra: hold the strobe.
                if (!wr_busy_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LOAD;
                end else begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (dref_i) begin
                        state_d = ST_ISSUE;
                    end else begin
                        complete_s = 1'b1;
                        row_d      = row_q + ROW_WIDTH'(1);
                        skip_d     = (skip_q != 16'hFFFF) ? (skip_q + 16'd1) : skip_q;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (ref_ack_i) begin
                    complete_s = 1'b1;
                    row_d      = row_q + ROW_WIDTH'(1);
                    cnt_d      = RFC_LOAD;
                    state_d    = ST_RECOVER;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owed-slot counter: ticks add (saturating), completions subtract.
    always_comb begin
        pend_d = pend_q;
        if (tick_s && !complete_s) begin
            pend_d = (pend_q >= PEND_MAX) ? pend_q : (pend_q + 4'd1);
        end else if (complete_s && !tick_s) begin
            pend_d = (pend_q != 4'd0) ? (pend_q - 4'd1) : pend_q;
        end else begin
            pend_d = pend_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            timer_q <= TMR_RELOAD;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            pend_q  <= 4'd0;
            skip_q  <= 16'd0;
        end else begin
            timer_q <= timer_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            skip_q  <= skip_d;
        end
    end

    assign to_refresh_o = (state_q == ST_LOOKUP) && !wr_busy_i;
    assign clk_enable_o = (state_q == ST_LOOKUP) || (state_q == ST_WAIT);
    assign ref_req_o    = (state_q == ST_ISSUE);
    assign ref_urgent_o = (pend_q >= PEND_URG);
    assign ref_row_o    = row_q;
    assign pending_o    = pend_q;
    assign skip_cnt_o   = skip_q;

endmodule

// File: tb/tb_wupr_refresh_scheduler.sv
// Table-driven bench for wupr_refresh_scheduler (ROW_WIDTH=4, TREFI=16,
// TRFC=4, DREF_LAT=1). Each record applies inputs, advances n clock edges
// and compares every output against hand-computed values.
module tb_wupr_refresh_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, refresh_en, wr_busy, dref, ref_ack;
    logic        to_refresh, clk_enable, ref_req, ref_urgent;
    logic [3:0]  ref_row;
    logic [3:0]  pending;
    logic [15:0] skip_cnt;

    int total = 0;
    int bad   = 0;

    // inputs packed as {rst_n, refresh_en, wr_busy, dref, ref_ack}
    localparam logic [4:0] RST = 5'b01000;
    localparam logic [4:0] R0  = 5'b11000;
    localparam logic [4:0] R1  = 5'b11010;
    localparam logic [4:0] RA  = 5'b11011;
    localparam logic [4:0] W1  = 5'b11100;

    // flags packed as {to_refresh, clk_enable, ref_req, ref_urgent}
    typedef struct {
        logic [4:0]  in_v;
        int          n;
        logic [3:0]  fl;
        logic [3:0]  pend;
        logic [3:0]  row;
        logic [15:0] skip;
    } vec_t;

    vec_t vecs[$];

    wupr_refresh_scheduler #(
        .ROW_WIDTH(4), .TREFI(16), .TRFC(4), .DREF_LAT(1),
        .MAX_PENDING(8), .URGENT_TH(6)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .refresh_en_i(refresh_en),
        .wr_busy_i(wr_busy), .to_refresh_o(to_refresh), .ref_row_o(ref_row),
        .clk_enable_o(clk_enable), .dref_i(dref), .ref_req_o(ref_req),
        .ref_ack_i(ref_ack), .ref_urgent_o(ref_urgent), .pending_o(pending),
        .skip_cnt_o(skip_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] in_v, input int n, input logic [3:0] fl,
                                input logic [3:0] pend, input logic [3:0] row,
                                input logic [15:0] skip);
        vec_t v;
        v.in_v = in_v; v.n = n; v.fl = fl; v.pend = pend; v.row = row; v.skip = skip;
        return v;
    endfunction

    initial begin
        int cyc;
        logic [27:0] act, exp;
        rst_n = 1'b0; refresh_en = 1'b0; wr_busy = 1'b0; dref = 1'b0; ref_ack = 1'b0;

        // skip path: tick after 16 edges, lookup, skip
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R0, 15,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b0000, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b1100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b0100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b0000, 4'd0, 4'd1, 16'd1));
        // refresh path: ref_req for 4 cycles, ack on the 4th
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0000, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b1100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b0100, 4'd1, 4'd0, 16'd0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(R1, 1, 4'b0010, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(RA,  1,  4'b0000, 4'd0, 4'd1, 16'd0));
        vecs.push_back(mk(R1,  4,  4'b0000, 4'd0, 4'd1, 16'd0));
        // postpone / urgent / saturation, then recovery gating, then reset mid-ISSUE
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0000, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R1,  3,  4'b0010, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 61,  4'b0010, 4'd5, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0011, 4'd6, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0011, 4'd7, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0011, 4'd8, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 16,  4'b0011, 4'd8, 4'd0, 16'd0));
        vecs.push_back(mk(RA,  1,  4'b0001, 4'd7, 4'd1, 16'd0));
        vecs.push_back(mk(R1,  4,  4'b0001, 4'd7, 4'd1, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b1101, 4'd7, 4'd1, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b0101, 4'd7, 4'd1, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b0011, 4'd7, 4'd1, 16'd0));
        vecs.push_back(mk(RA,  1,  4'b0001, 4'd6, 4'd2, 16'd0));
        vecs.push_back(mk(R1,  7,  4'b0011, 4'd7, 4'd2, 16'd0));
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R1, 15,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R1,  1,  4'b0000, 4'd1, 4'd0, 16'd0));
        // write collision, including wr_busy rising during LOOKUP
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R0, 16,  4'b0000, 4'd1, 4'd0, 16'd0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(W1, 1, 4'b0000, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b1100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(W1,  0,  4'b0100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(W1,  1,  4'b0100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  0,  4'b1100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b0100, 4'd1, 4'd0, 16'd0));
        vecs.push_back(mk(R0,  1,  4'b0000, 4'd0, 4'd1, 16'd1));
        // row pointer wrap after 16 skips
        vecs.push_back(mk(RST, 1,  4'b0000, 4'd0, 4'd0, 16'd0));
        vecs.push_back(mk(R0, 258, 4'b0100, 4'd1, 4'd15, 16'd15));
        vecs.push_back(mk(R0,  1,  4'b0000, 4'd0, 4'd0, 16'd16));

        foreach (vecs[i]) begin
            {rst_n, refresh_en, wr_busy, dref, ref_ack} = vecs[i].in_v;
            repeat (vecs[i].n) @(posedge clk);
            #1;
            act = {to_refresh, clk_enable, ref_req, ref_urgent, pending, ref_row, skip_cnt};
            exp = {vecs[i].fl, vecs[i].pend, vecs[i].row, vecs[i].skip};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL vec%0d: got tr/ce/req/urg=%b pend=%0d row=%0d skip=%0d, want tr/ce/req/urg=%b pend=%0d row=%0d skip=%0d",
                         i, act[27:24], act[23:20], act[19:16], act[15:0],
                         exp[27:24], exp[23:20], exp[19:16], exp[15:0]);
            end
        end

        // first lookup latency after reset, bounded wait
        {rst_n, refresh_en, wr_busy, dref, ref_ack} = RST;
        @(posedge clk); #1;
        {rst_n, refresh_en, wr_busy, dref, ref_ack} = R0;
        cyc = 0;
        while (cyc < 40 && to_refresh !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 17) begin
            bad++;
            $display("FAIL first_lookup: got to_refresh after %0d edges, want 17", cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
